// File: rtl/network_sink_pkg.sv
// Shared configuration for the network return path: network geometry, stream
// packet width, and the packet layout helpers used by network_sink.
package network_config;
  localparam int NUM_OUT = 4;
endpackage

package stream_config;
  localparam int PKT_WIDTH = 8;
endpackage

package sink_config;
  import network_config::*;
  import stream_config::*;

  localparam int PFX_WIDTH = 1;
  localparam int EMP       = 0;
  localparam int SPK_WIDTH = NUM_OUT;

  // net_out is copied MSB-aligned directly under the flag bit.
  function automatic logic [PKT_WIDTH-1:0] make_spike_pkt(input logic [SPK_WIDTH-1:0] spk);
    logic [PKT_WIDTH-1:0] p;
    p = '0;
    p[PKT_WIDTH-1-PFX_WIDTH -: SPK_WIDTH] = spk;
    return p;
  endfunction

  function automatic logic [PKT_WIDTH-1:0] make_idle_pkt(input logic [PKT_WIDTH-2:0] cnt);
    logic [PKT_WIDTH-1:0] p;
    p = '0;
    p[PKT_WIDTH-2:0] = cnt;
    p[PKT_WIDTH-1-EMP] = 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/network_sink_fifo.sv
// Dual-write / single-read packet FIFO with a registered head entry and a
// free-slot count for upstream flow control.
module pkt_fifo2w #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             i_push0,
  input  logic             i_push1,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [AW:0]      o_free
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;
  logic             w_pop;
  logic [AW:0]      w_wr_p1;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop     = i_pop && r_valid;
  assign w_wr_p1   = r_wr + (AW+1)'(1);
  assign w_wr_nxt  = r_wr + (AW+1)'(i_push0) + (AW+1)'(i_push1);
  assign w_rd_nxt  = r_rd + (AW+1)'(w_pop);
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  // The next head may be an entry being written this very cycle, so bypass it.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    if (i_push0 && (w_rd_nxt == r_wr)) begin
      w_head_nxt = i_data0;
    end else if (i_push1 && (w_rd_nxt == w_wr_p1)) begin
      w_head_nxt = i_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr[AW-1:0]] <= i_data0;
    if (i_push1) r_mem[w_wr_p1[AW-1:0]] <= i_data1;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_valid <= (w_cnt_nxt != '0);
      r_head  <= (w_cnt_nxt != '0) ? w_head_nxt : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_free  = (AW+1)'(DEPTH) - (r_wr - r_rd);
endmodule

// File: rtl/network_sink.sv
// Packs per-run output fire vectors into stream packets, collapsing runs of
// silent outputs into a single idle-count packet.
module network_sink #(
  parameter int PKT_WIDTH  = stream_config::PKT_WIDTH,
  parameter int RUN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic                              net_valid,
  output logic                              net_ready,
  input  logic                              net_sync,
  input  logic [network_config::NUM_OUT-1:0] net_out,
  output logic                              snk_valid,
  input  logic                              snk_ready,
  output logic [PKT_WIDTH-1:0]              snk
);
  import sink_config::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic                 r_net_ready;
  logic [RUN_WIDTH-1:0] r_cnt;
  logic [RUN_WIDTH-1:0] w_cnt_inc;
  logic [RUN_WIDTH-1:0] w_cnt_nxt;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_push0;
  logic                 w_push1;
  logic [PKT_WIDTH-1:0] w_data0;
  logic [PKT_WIDTH-1:0] w_data1;
  logic [1:0]           w_nwr;
  logic [AW:0]          w_free;
  logic [AW+1:0]        w_free_after;

  assign w_accept  = net_valid && r_net_ready;
  assign w_pop     = snk_valid && snk_ready;
  assign w_cnt_inc = r_cnt + RUN_WIDTH'(1);

  // A nonzero run first flushes any pending idle count so ordering is kept.
  always_comb begin
    w_push0   = 1'b0;
    w_push1   = 1'b0;
    w_data0   = '0;
    w_data1   = '0;
    w_cnt_nxt = r_cnt;
    if (w_accept) begin
      if (net_out == '0) begin
        if ((w_cnt_inc == '1) || net_sync) begin
          w_push0   = 1'b1;
          w_data0   = make_idle_pkt((PKT_WIDTH-1)'(w_cnt_inc));
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end else begin
        w_cnt_nxt = '0;
        if (r_cnt != '0) begin
          w_push0 = 1'b1;
          w_data0 = make_idle_pkt((PKT_WIDTH-1)'(r_cnt));
          w_push1 = 1'b1;
          w_data1 = make_spike_pkt(net_out);
        end else begin
          w_push0 = 1'b1;
          w_data0 = make_spike_pkt(net_out);
        end
      end
    end
  end

  assign w_nwr        = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_free_after = (AW+2)'(w_free) - (AW+2)'(w_nwr) + (AW+2)'(w_pop);

  // Keeping two slots in reserve lets any accepted run push twice safely.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt       <= '0;
      r_net_ready <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_net_ready <= (w_free_after >= (AW+2)'(2));
    end
  end

  assign net_ready = r_net_ready;

  pkt_fifo2w #(
    .WIDTH (PKT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .i_push0 (w_push0),
    .i_push1 (w_push1),
    .i_data0 (w_data0),
    .i_data1 (w_data1),
    .i_pop   (snk_ready),
    .o_valid (snk_valid),
    .o_head  (snk),
    .o_free  (w_free)
  );
endmodule
